paddle_input_ctrl: RTL and testbench
====================================

# paddle_input_ctrl

Conditions the two raw player buttons into clean, time-limited swing requests for the ping-pong game core. Each raw button is synchronised, debounced and converted into a swing window. The window stays asserted for a fixed number of game steps and then locks out until the button is released. Its outputs drive the game core's `LeftSw`/`RightSw` inputs, so a held button can never return every ball.

## Interface
- `DEBOUNCE_CYCLES`, 250000: consecutive `clk` cycles a synchronised level must be stable before the debounced level changes; ≥1.
- `SWING_TICKS`, 2: `game_tick` strobes for which a swing stays asserted; ≥1.
- `COOLDOWN_TICKS`, 3: `game_tick` strobes of lockout after release (only with `PADDLE_COOLDOWN_EN`); ≥1.

- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `btn_left`  in  1  raw left-player button, asynchronous to `clk`, bouncing.
- `btn_right`  in  1  raw right-player button, asynchronous to `clk`, bouncing.
- `game_tick`  in  1  one-`clk`-cycle strobe per game step, aligned to the game core's step.
- `LeftSw`  out  1  left swing window, registered.
- `RightSw`  out  1  right swing window, registered.
- `left_ready`  out  1  high only in IDLE: a left press will start a swing.
- `right_ready`  out  1  high only in IDLE: a right press will start a swing.

## Operation
- There are two identical, fully independent channels (left, right). Nothing is shared except `clk`, `rst_n` and `game_tick`.
- Per channel, the pipeline is: 2-flop synchroniser → debouncer → FSM.
- Debouncer:
  - A counter of width clog2(`DEBOUNCE_CYCLES`)+1 increments each cycle while the synchronised level differs from the debounced level.
  - It clears to 0 whenever the two levels match.
  - The debounced level flips on the cycle the counter reaches `DEBOUNCE_CYCLES`-1 while the mismatch still holds. The counter then clears.
- FSM states:
  - **IDLE**: `Sw`=0, `ready`=1. Debounced level high → SWING.
  - **SWING**: `Sw`=1. The tick counter counts `game_tick` only in cycles where the registered state is already SWING, so a tick in the entry cycle does not count. On the `SWING_TICKS`-th counted tick → WAIT_RELEASE.
  - **WAIT_RELEASE**: `Sw`=0. Debounced level low → COOLDOWN, or straight to IDLE when the macro is undefined.
  - **COOLDOWN**: `Sw`=0. On the `COOLDOWN_TICKS`-th counted tick → IDLE.
- Boundary rules:
  - Release during SWING does not shorten the window. The full `SWING_TICKS` always elapse.
  - Re-press during COOLDOWN is ignored. If the button is still held when COOLDOWN ends, IDLE immediately starts a new SWING on the next cycle; this is intended.
  - Tick counters use clog2(max(`SWING_TICKS`,`COOLDOWN_TICKS`))+1 bits and clear on every state entry. They never wrap.
  - `game_tick` held high is treated as one tick per cycle.
  - Simultaneous left and right presses produce simultaneous windows. Arbitration belongs to the game core.
- Reset:
  - Asserting `rst_n`=0 at any time forces both channels to IDLE.
  - Synchroniser flops, debounced levels and all counters clear to 0.
  - Reset values: `LeftSw`=`RightSw`=0, `left_ready`=`right_ready`=1.
  - A button held through reset release is seen as a fresh press after the debounce delay.

## Timing
- Press latency: take edge 0 as the first rising edge sampling raw high, with the raw input stable thereafter.
  - Debounced level rises after edge `DEBOUNCE_CYCLES`+1.
  - `Sw` rises after edge `DEBOUNCE_CYCLES`+2.
- Swing end: `Sw` falls one cycle after the edge that registers the final counted tick.
- Release latency: WAIT_RELEASE exits one cycle after the debounced level falls, i.e. after edge `DEBOUNCE_CYCLES`+2 counted from the first low sample.
- `ready` changes in the same cycle as the state register.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles never reach the FSM.

## Configuration
- `PADDLE_COOLDOWN_EN` defined:
  - The COOLDOWN state and `COOLDOWN_TICKS` are compiled in.
  - WAIT_RELEASE → COOLDOWN → IDLE.
- `PADDLE_COOLDOWN_EN` undefined:
  - COOLDOWN logic is absent and WAIT_RELEASE → IDLE directly.
  - `COOLDOWN_TICKS` is ignored.

## Test plan
Bench settings: `DEBOUNCE_CYCLES`=4, `SWING_TICKS`=2, `COOLDOWN_TICKS`=3, `game_tick` every 10 cycles, `PADDLE_COOLDOWN_EN` defined unless stated.
- **Reset values**: `rst_n`=0 → `LeftSw`=`RightSw`=0 and both `ready`=1, held for the whole reset.
- **Clean press**: `btn_left` rises at edge 0 and stays high.
  - `LeftSw`=1 after edge 6.
  - `LeftSw` falls one cycle after the 2nd counted tick.
  - `LeftSw` stays 0 while the button is held.
  - `RightSw`=0 throughout.
- **Bounce**: `btn_right` toggles every 2 cycles for 30 cycles, then stays low → `RightSw` never asserts and `right_ready` stays 1.
- **Cooldown**:
  - Release after the swing, re-press within 3 ticks and hold → no swing until 3 ticks after release.
  - Then `LeftSw`=1 one cycle after IDLE is entered.
- **Cooldown compiled out**: macro undefined, release then re-press → new `LeftSw` pulse appears 6 edges after the re-press's first high sample.
- **Mid-operation reset**: `rst_n` dropped during SWING → `LeftSw`=0 immediately (asynchronously); button held through release → `LeftSw`=1 six edges after `rst_n` rises.

Source files
------------

// File: rtl/paddle_input_ctrl_if.sv
// paddle_input_ctrl_if: groups the raw button and tick inputs with the conditioned swing outputs.
//   btn_left, btn_right : raw player buttons (asynchronous, bouncing)
//   game_tick           : one-cycle strobe per game step
//   LeftSw, RightSw     : swing windows driven to the game core
//   left_ready,
//   right_ready         : channel idle, next press starts a swing
// master drives the buttons and tick; slave (the controller) drives the swing and ready outputs.
interface paddle_input_ctrl_if;
   logic btn_left;
   logic btn_right;
   logic game_tick;
   logic LeftSw;
   logic RightSw;
   logic left_ready;
   logic right_ready;

   modport master (
      output btn_left, btn_right, game_tick,
      input  LeftSw, RightSw, left_ready, right_ready
   );

   modport slave (
      input  btn_left, btn_right, game_tick,
      output LeftSw, RightSw, left_ready, right_ready
   );
endinterface

// File: rtl/paddle_input_ctrl.sv
// paddle_input_ctrl: turns the two raw player buttons into time-limited swing windows.
// Each channel runs a 2-flop synchroniser, a debouncer and a swing FSM
// (IDLE -> SWING -> WAIT_RELEASE [-> COOLDOWN] -> IDLE).
// Optional feature macro: PADDLE_COOLDOWN_EN adds the post-release COOLDOWN lockout.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : paddle_input_ctrl_if.slave (buttons, game_tick in; LeftSw/RightSw, ready out)
module paddle_input_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned SWING_TICKS     = 2,
   parameter int unsigned COOLDOWN_TICKS  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   paddle_input_ctrl_if.slave    bus
);

   localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int unsigned TICK_MAX = (SWING_TICKS > COOLDOWN_TICKS) ? SWING_TICKS : COOLDOWN_TICKS;
   localparam int unsigned TICK_W   = $clog2(TICK_MAX) + 1;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_SWING        = 2'd1,
      ST_WAIT_RELEASE = 2'd2
`ifdef PADDLE_COOLDOWN_EN
      ,
      ST_COOLDOWN     = 2'd3
`endif
   } state_t;

   for (genvar ch = 0; ch < 2; ch++) begin : g_ch
      logic              btn_raw;
      logic              sync1_q;
      logic              sync2_q;
      logic              db_q;
      logic [DB_W-1:0]   db_cnt_q;
      state_t            state_q;
      state_t            state_d;
      logic [TICK_W-1:0] tick_q;
      logic [TICK_W-1:0] tick_d;
      logic              sw_q;
      logic              sw_d;
      logic              ready_q;
      logic              ready_d;

      // channel 0 is the left player, channel 1 the right player
      if (ch == 0) begin : g_left
         assign btn_raw        = bus.btn_left;
         assign bus.LeftSw     = sw_q;
         assign bus.left_ready = ready_q;
      end else begin : g_right
         assign btn_raw         = bus.btn_right;
         assign bus.RightSw     = sw_q;
         assign bus.right_ready = ready_q;
      end

      // synchroniser and debouncer: level must disagree for DEBOUNCE_CYCLES cycles to flip
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            db_q     <= 1'b0;
            db_cnt_q <= '0;
         end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            if (sync2_q == db_q) begin
               db_cnt_q <= '0;
            end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               db_q     <= sync2_q;
               db_cnt_q <= '0;
            end else begin
               db_cnt_q <= db_cnt_q + DB_W'(1);
            end
         end
      end

      // swing FSM next state; a tick only counts once the registered state is already in place
      always_comb begin
         state_d = state_q;
         tick_d  = tick_q;
         case (state_q)
            ST_IDLE: begin
               if (db_q) state_d = ST_SWING;
            end
            ST_SWING: begin
               if (tick_q == TICK_W'(SWING_TICKS)) state_d = ST_WAIT_RELEASE;
               else if (bus.game_tick)             tick_d  = tick_q + TICK_W'(1);
            end
            ST_WAIT_RELEASE: begin
`ifdef PADDLE_COOLDOWN_EN
               if (!db_q) state_d = ST_COOLDOWN;
`else
               if (!db_q) state_d = ST_IDLE;
`endif
            end
`ifdef PADDLE_COOLDOWN_EN
            ST_COOLDOWN: begin
               if (tick_q == TICK_W'(COOLDOWN_TICKS)) state_d = ST_IDLE;
               else if (bus.game_tick)                tick_d  = tick_q + TICK_W'(1);
            end
`endif
            default: state_d = ST_IDLE;
         endcase
         // every state entry starts its tick count from zero
         if (state_d != state_q) tick_d = '0;
         sw_d    = (state_d == ST_SWING);
         ready_d = (state_d == ST_IDLE);
      end

      // state, tick counter and registered outputs
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= ST_IDLE;
            tick_q  <= '0;
            sw_q    <= 1'b0;
            ready_q <= 1'b1;
         end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            sw_q    <= sw_d;
            ready_q <= ready_d;
         end
      end
   end

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// tb_paddle_input_ctrl: directed self-checking bench for paddle_input_ctrl.
// Runs with DEBOUNCE_CYCLES=4, SWING_TICKS=2, COOLDOWN_TICKS=3; the release/re-press
// section follows whichever PADDLE_COOLDOWN_EN setting the design was built with.
module tb_paddle_input_ctrl;

   localparam int unsigned DEB = 4;
   localparam int unsigned SWT = 2;
   localparam int unsigned CDT = 3;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   paddle_input_ctrl_if bus ();

   paddle_input_ctrl #(
      .DEBOUNCE_CYCLES (DEB),
      .SWING_TICKS     (SWT),
      .COOLDOWN_TICKS  (CDT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // advance n rising edges, landing 1 time unit after the last one
   task automatic adv(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.btn_left  = 1'b0;
      bus.btn_right = 1'b0;
      bus.game_tick = 1'b0;

      // reset values, held while reset is asserted
      for (int i = 0; i < 3; i++) begin
         adv(1);
         check("rst_left_sw", bus.LeftSw, 1'b0);
         check("rst_right_sw", bus.RightSw, 1'b0);
         check("rst_left_ready", bus.left_ready, 1'b1);
         check("rst_right_ready", bus.right_ready, 1'b1);
      end
      rst_n = 1'b1;
      adv(2);
      check("idle_left_ready", bus.left_ready, 1'b1);

      // bounce on right: 2 high, 2 low, never stable long enough
      for (int i = 0; i < 30; i++) begin
         bus.btn_right = ((i / 2) % 2 == 0);
         adv(1);
         check("bounce_right_sw", bus.RightSw, 1'b0);
         check("bounce_right_ready", bus.right_ready, 1'b1);
      end
      bus.btn_right = 1'b0;
      for (int i = 0; i < 8; i++) begin
         adv(1);
         check("bounce_settle_sw", bus.RightSw, 1'b0);
         check("bounce_settle_ready", bus.right_ready, 1'b1);
      end

      // clean left press: swing rises after edge 6
      bus.btn_left = 1'b1;
      for (int i = 0; i <= 6; i++) begin
         adv(1);
         check("press_left_sw", bus.LeftSw, (i == 6));
         check("press_left_ready", bus.left_ready, (i != 6));
         check("press_right_sw", bus.RightSw, 1'b0);
      end
      // two counted ticks, then the window closes one cycle later
      bus.game_tick = 1'b1;
      adv(1);
      bus.game_tick = 1'b0;
      check("swing_tick1_sw", bus.LeftSw, 1'b1);
      adv(9);
      check("swing_mid_sw", bus.LeftSw, 1'b1);
      bus.game_tick = 1'b1;
      adv(1);
      bus.game_tick = 1'b0;
      check("swing_tick2_sw", bus.LeftSw, 1'b1);
      adv(1);
      check("swing_end_sw", bus.LeftSw, 1'b0);
      check("swing_end_ready", bus.left_ready, 1'b0);
      // held button never reopens the window
      for (int i = 0; i < 20; i++) begin
         bus.game_tick = (i % 10 == 0);
         adv(1);
         check("hold_left_sw", bus.LeftSw, 1'b0);
         check("hold_left_ready", bus.left_ready, 1'b0);
         check("hold_right_sw", bus.RightSw, 1'b0);
      end
      bus.game_tick = 1'b0;

      // release: debounced low after edge 5, WAIT_RELEASE exits at edge 6
      bus.btn_left = 1'b0;
`ifdef PADDLE_COOLDOWN_EN
      for (int i = 0; i <= 6; i++) begin
         adv(1);
         check("release_cd_ready", bus.left_ready, 1'b0);
         check("release_cd_sw", bus.LeftSw, 1'b0);
      end
      // COOLDOWN entered; re-press immediately and hold, it must be ignored for 3 ticks
      bus.btn_left = 1'b1;
      for (int t = 0; t < 3; t++) begin
         bus.game_tick = 1'b1;
         adv(1);
         bus.game_tick = 1'b0;
         check("cooldown_tick_sw", bus.LeftSw, 1'b0);
         check("cooldown_tick_ready", bus.left_ready, 1'b0);
         if (t < 2) begin
            for (int k = 0; k < 9; k++) begin
               adv(1);
               check("cooldown_wait_sw", bus.LeftSw, 1'b0);
            end
         end
      end
      adv(1);
      check("cooldown_idle_ready", bus.left_ready, 1'b1);
      check("cooldown_idle_sw", bus.LeftSw, 1'b0);
      adv(1);
      check("cooldown_reswing_sw", bus.LeftSw, 1'b1);
      check("cooldown_reswing_ready", bus.left_ready, 1'b0);
`else
      for (int i = 0; i <= 6; i++) begin
         adv(1);
         check("release_ready", bus.left_ready, (i == 6));
         check("release_sw", bus.LeftSw, 1'b0);
      end
      // no lockout: a re-press swings after the normal press latency
      bus.btn_left = 1'b1;
      for (int i = 0; i <= 6; i++) begin
         adv(1);
         check("repress_left_sw", bus.LeftSw, (i == 6));
         check("repress_left_ready", bus.left_ready, (i != 6));
      end
`endif

      // asynchronous reset in the middle of a swing
      bus.btn_right = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_left_sw", bus.LeftSw, 1'b0);
      check("async_rst_left_ready", bus.left_ready, 1'b1);
      adv(3);
      check("in_rst_right_sw", bus.RightSw, 1'b0);
      rst_n = 1'b1;
      // both buttons held through reset release swing together; tick goes high at entry
      for (int i = 0; i <= 6; i++) begin
         if (i == 6) bus.game_tick = 1'b1;
         adv(1);
         check("post_rst_left_sw", bus.LeftSw, (i == 6));
         check("post_rst_right_sw", bus.RightSw, (i == 6));
      end
      // tick held high: entry cycle not counted, then one tick per cycle
      adv(1);
      check("held_tick1_left_sw", bus.LeftSw, 1'b1);
      adv(1);
      check("held_tick2_left_sw", bus.LeftSw, 1'b1);
      check("held_tick2_right_sw", bus.RightSw, 1'b1);
      adv(1);
      bus.game_tick = 1'b0;
      check("held_end_left_sw", bus.LeftSw, 1'b0);
      check("held_end_right_sw", bus.RightSw, 1'b0);
      check("held_end_right_ready", bus.right_ready, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
